// File: rtl/bufz_bus_arbiter.sv
// bufz_bus_arbiter: round-robin break-before-make arbiter driving a bank of tristate bus buffers
module bufz_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*DW-1:0]   DIN,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      EN,
    output logic [NREQ*DW-1:0]   I,
    output logic                 BUSY
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, DRIVE, TURNAROUND} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, ptr_nxt, own, own_nxt, win;
    logic [7:0]          hold, hold_nxt;
    logic [2:0]          turn, turn_nxt;
    logic [NREQ-1:0]     gnt_nxt;
    logic [NREQ*DW-1:0]  i_nxt;
    logic                found, others, release_bus, decide;
    int                  idx;

    assign EN          = GNT;
    assign BUSY        = state != IDLE;
    assign others      = |(REQ & ~GNT);
    assign release_bus = !REQ[own] || (hold == 8'(MAXHOLD) && others);
    assign decide      = state == IDLE || (state == TURNAROUND && turn == 3'(TURN));

    // first requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // next state, grant, data, counters
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        own_nxt   = own;
        hold_nxt  = hold;
        turn_nxt  = turn;
        gnt_nxt   = GNT;
        i_nxt     = I;
        if (state == DRIVE)
            i_nxt[own*DW +: DW] = DIN[own*DW +: DW];
        if (decide && found) begin
            state_nxt           = DRIVE;
            own_nxt             = win;
            ptr_nxt             = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            hold_nxt            = 8'd1;
            gnt_nxt             = {{(NREQ-1){1'b0}}, 1'b1} << win;
            i_nxt[win*DW +: DW] = DIN[win*DW +: DW];
        end else if (state == TURNAROUND) begin
            if (turn == 3'(TURN))
                state_nxt = IDLE;
            else
                turn_nxt = turn + 3'd1;
        end else if (state == DRIVE) begin
            if (release_bus) begin
                state_nxt = TURNAROUND;
                gnt_nxt   = '0;
                turn_nxt  = 3'd1;
            end else if (hold != 8'(MAXHOLD)) begin
                hold_nxt = hold + 8'd1;
            end
        end
    end

    // state and output registers; reset drops EN at once
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            hold  <= '0;
            turn  <= '0;
            GNT   <= '0;
            I     <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            own   <= own_nxt;
            hold  <= hold_nxt;
            turn  <= turn_nxt;
            GNT   <= gnt_nxt;
            I     <= i_nxt;
        end
    end
endmodule

// File: tb/tb_bufz_bus_arbiter.sv
// tb_bufz_bus_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_bufz_bus_arbiter;
    localparam int NREQ = 4, DW = 8, MAXHOLD = 16, TURN = 1;

    logic        CLK = 1'b0, RN = 1'b0;
    logic [3:0]  REQ = '0, GNT, EN;
    logic [31:0] DIN = '0, I;
    logic        BUSY;
    logic [3:0]  req2 = '0, gnt2, en2;
    logic [31:0] din2 = '0, i2;
    logic        busy2;

    int n_chk = 0, n_pass = 0;

    int m_state, m_own, m_ptr, m_hold, m_turn;
    int m_i[NREQ];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic        busy;
        logic [31:0] i;
    } vec_t;
    vec_t vecs[9];

    bufz_bus_arbiter #(.NREQ(4), .DW(8), .TURN(1), .MAXHOLD(16)) dut (
        .CLK(CLK), .RN(RN), .REQ(REQ), .DIN(DIN), .GNT(GNT), .EN(EN), .I(I), .BUSY(BUSY));

    bufz_bus_arbiter #(.NREQ(4), .DW(8), .TURN(3), .MAXHOLD(16)) dut3 (
        .CLK(CLK), .RN(RN), .REQ(req2), .DIN(din2), .GNT(gnt2), .EN(en2), .I(i2), .BUSY(busy2));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_own = 0; m_ptr = 0; m_hold = 0; m_turn = 0;
        for (int k = 0; k < NREQ; k++) m_i[k] = 0;
    endtask

    task automatic model_grant();
        for (int n = 0; n < NREQ; n++) begin
            int k = (m_ptr + n) % NREQ;
            if (REQ[k]) begin
                m_state = 1; m_own = k; m_ptr = (k + 1) % NREQ; m_hold = 1;
                m_i[k] = int'(DIN[k*DW +: DW]);
                return;
            end
        end
        m_state = 0;
    endtask

    task automatic model_step();
        if (m_state == 0) begin
            model_grant();
        end else if (m_state == 1) begin
            m_i[m_own] = int'(DIN[m_own*DW +: DW]);
            if (!REQ[m_own] || (m_hold == MAXHOLD && (REQ & ~(4'b1 << m_own)) != 0)) begin
                m_state = 2; m_turn = 1;
            end else if (m_hold < MAXHOLD) begin
                m_hold++;
            end
        end else begin
            if (m_turn == TURN) model_grant();
            else m_turn++;
        end
    endtask

    task automatic tick();
        logic [31:0] ei;
        model_step();
        @(posedge CLK);
        #1;
        for (int k = 0; k < NREQ; k++) ei[k*DW +: DW] = m_i[k][7:0];
        chk("model_gnt", GNT, (m_state == 1) ? 4'b1 << m_own : 4'b0);
        chk("model_busy", BUSY, m_state != 0);
        chk("model_i", I, ei);
        chk("en_onehot", $countones(EN) <= 1, 1'b1);
        chk("en_eq_gnt", EN, GNT);
        chk("en3_onehot", $countones(en2) <= 1, 1'b1);
    endtask

    task automatic pulse_reset();
        REQ = '0;
        RN = 1'b0;
        #1;
        RN = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] trace[85];
        int bad, high;
        vecs[0] = '{4'b0010, 32'h0000_A500, 4'b0010, 1'b1, 32'h0000_A500};
        vecs[1] = '{4'b0010, 32'h0000_3C00, 4'b0010, 1'b1, 32'h0000_3C00};
        vecs[2] = '{4'b0000, 32'h0000_7700, 4'b0000, 1'b1, 32'h0000_7700};
        vecs[3] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 32'h0000_7700};
        vecs[4] = '{4'b1001, 32'h1100_0022, 4'b1000, 1'b1, 32'h1100_7700};
        vecs[5] = '{4'b0001, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_7700};
        vecs[6] = '{4'b0001, 32'h0000_0044, 4'b0001, 1'b1, 32'h0000_7744};
        vecs[7] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_7700};
        vecs[8] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 32'h0000_7700};
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_gnt", GNT, 4'b0);
        chk("reset_en", EN, 4'b0);
        chk("reset_i", I, 32'b0);
        chk("reset_busy", BUSY, 1'b0);
        RN = 1'b1;

        for (int v = 0; v < 9; v++) begin
            REQ = vecs[v].req;
            DIN = vecs[v].din;
            tick();
            chk($sformatf("vec%0d_gnt", v), GNT, vecs[v].gnt);
            chk($sformatf("vec%0d_busy", v), BUSY, vecs[v].busy);
            chk($sformatf("vec%0d_i", v), I, vecs[v].i);
        end

        req2 = 4'b0001;
        tick();
        chk("t3_grant0", gnt2, 4'b0001);
        req2 = 4'b1000;
        tick();
        chk("t3_release", en2, 4'b0000);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("t3_dead%0d", c + 2), en2, 4'b0000);
        end
        tick();
        chk("t3_grant3", en2, 4'b1000);
        req2 = 4'b0000;

        pulse_reset();
        REQ = 4'b1111;
        for (int c = 0; c < 85; c++) begin
            tick();
            trace[c] = GNT;
        end
        bad = 0;
        for (int c = 0; c < 85; c++)
            if (trace[c] !== (((c % 17) < 16) ? 4'b1 << ((c / 17) % 4) : 4'b0)) bad++;
        chk("rotation_trace_errors", bad, 0);

        pulse_reset();
        REQ = 4'b0010;
        high = 0;
        for (int c = 0; c < 100; c++) begin
            DIN = $urandom;
            tick();
            if (EN == 4'b0010) high++;
        end
        chk("solo_hold_cycles", high, 100);

        #3;
        RN = 1'b0;
        #1;
        chk("async_en", EN, 4'b0);
        chk("async_gnt", GNT, 4'b0);
        chk("async_i", I, 32'b0);
        chk("async_busy", BUSY, 1'b0);
        RN = 1'b1;
        model_reset();
        REQ = 4'b1000;
        tick();
        chk("post_reset_grant", GNT, 4'b1000);

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++)
                if ($urandom_range(0, 5) == 0) REQ[k] = ~REQ[k];
            DIN = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
